// File: rtl/ejtag_mem_bridge.sv
// EJTAG memory bridge: turns ADDRESS/DATA/CONTROL register updates into
// single byte/half/word bus accesses with status, autoinc and timeout.
//
// Ports:
//   TCK, TRST        clock (rising edge) and async active-low reset
//   upd_addr/addr_in ADDRESS register update pulse and value
//   upd_data/data_in DATA register update pulse and value
//   upd_ctrl/ctrl_in CONTROL update: [0] GO [1] WRITE [3:2] SIZE
//                    [4] AUTOINC [5] CLRERR
//   data_cap         read data (zero-extended lane) for DATA capture
//   ctrl_cap         status: [0] BUSY [1] DONE [2] ERR [3] TIMEOUT
//                    [4] ALIGN [5] OVERRUN [15:8] timeout count
//   busy             access in flight
//   bus_*            request/response bus, one access at a time
module ejtag_mem_bridge #(
  parameter int TIMEOUT = 255
) (
  input  logic        TCK,
  input  logic        TRST,
  input  logic        upd_addr,
  input  logic [31:0] addr_in,
  input  logic        upd_data,
  input  logic [31:0] data_in,
  input  logic        upd_ctrl,
  input  logic [31:0] ctrl_in,
  output logic [31:0] data_cap,
  output logic [31:0] ctrl_cap,
  output logic        busy,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata
);

  localparam logic [31:0] TO = 32'(TIMEOUT);

  typedef enum logic {IDLE, BUS} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, data_q, dcap_q, cnt_q;
  logic [1:0]  size_q;
  logic        we_q, inc_q;
  logic        done_q, err_q, tmo_q, algn_q, ovr_q;

  logic        in_bus, go, clr, misal;
  logic        start, bad, ok, fail;
  logic        tmo_hit, ovr_hit;
  logic [31:0] cnt_inc, step;
  logic [3:0]  be;
  logic [31:0] wdat, rd_lane;
  logic [7:0]  rd_byte, cnt_sat;
  logic        ctrl_unused;

  assign ctrl_unused = ^ctrl_in[31:6];

  assign in_bus  = (state_q == BUS);
  assign go      = upd_ctrl & ctrl_in[0];
  assign clr     = upd_ctrl & ctrl_in[5];
  assign start   = ~in_bus & go & ~misal;
  assign bad     = ~in_bus & go & misal;
  assign ok      = in_bus & bus_ack & ~bus_err;
  assign fail    = in_bus & bus_err;
  assign cnt_inc = cnt_q + 32'd1;
  // ack/err in the same cycle beat the timeout
  assign tmo_hit = in_bus & ~bus_ack & ~bus_err
                 & (cnt_inc >= TO);
  assign ovr_hit = in_bus & (upd_addr | upd_data | go);

  // alignment uses the already-latched address
  always_comb begin
    misal = 1'b0;
    unique case (ctrl_in[3:2])
      2'b00: misal = 1'b0;
      2'b01: misal = addr_q[0];
      2'b10: misal = |addr_q[1:0];
      2'b11: misal = 1'b1;
    endcase
  end

  always_comb begin
    rd_byte = bus_rdata[7:0];
    unique case (addr_q[1:0])
      2'b00: rd_byte = bus_rdata[7:0];
      2'b01: rd_byte = bus_rdata[15:8];
      2'b10: rd_byte = bus_rdata[23:16];
      2'b11: rd_byte = bus_rdata[31:24];
    endcase
  end

  always_comb begin
    be      = 4'b1111;
    wdat    = data_q;
    rd_lane = bus_rdata;
    step    = 32'd4;
    unique case (size_q)
      2'b00: begin
        be      = 4'b0001 << addr_q[1:0];
        wdat    = {4{data_q[7:0]}};
        rd_lane = {24'd0, rd_byte};
        step    = 32'd1;
      end
      2'b01: begin
        be      = addr_q[1] ? 4'b1100 : 4'b0011;
        wdat    = {2{data_q[15:0]}};
        rd_lane = addr_q[1] ? {16'd0, bus_rdata[31:16]}
                            : {16'd0, bus_rdata[15:0]};
        step    = 32'd2;
      end
      default: begin
        be      = 4'b1111;
        wdat    = data_q;
        rd_lane = bus_rdata;
        step    = 32'd4;
      end
    endcase
  end

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == IDLE): if (start) state_d = BUS;
      (state_q == BUS):
        if (bus_ack | bus_err | tmo_hit) state_d = IDLE;
    endcase
  end

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      addr_q <= '0;
      data_q <= '0;
      dcap_q <= '0;
      cnt_q  <= '0;
      size_q <= '0;
      we_q   <= 1'b0;
      inc_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      tmo_q  <= 1'b0;
      algn_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      if (!in_bus && upd_addr) addr_q <= addr_in;
      if (!in_bus && upd_data) data_q <= data_in;
      if (!in_bus && go) done_q <= 1'b0;
      if (start) begin
        we_q   <= ctrl_in[1];
        size_q <= ctrl_in[3:2];
        inc_q  <= ctrl_in[4];
        cnt_q  <= '0;
      end
      if (in_bus && !bus_ack && !bus_err)
        cnt_q <= cnt_inc;
      if (ok) begin
        done_q <= 1'b1;
        if (!we_q) dcap_q <= rd_lane;
        if (inc_q) addr_q <= addr_q + step;
      end
      // clear first, a same-edge event re-sets the bit
      err_q  <= (err_q  & ~clr) | fail;
      tmo_q  <= (tmo_q  & ~clr) | tmo_hit;
      algn_q <= (algn_q & ~clr) | bad;
      ovr_q  <= (ovr_q  & ~clr) | ovr_hit;
    end
  end

  assign cnt_sat = (|cnt_q[31:8]) ? 8'hFF : cnt_q[7:0];

  assign bus_req   = in_bus;
  assign busy      = in_bus;
  assign bus_we    = in_bus & we_q;
  assign bus_addr  = in_bus ? addr_q : '0;
  assign bus_be    = in_bus ? be : '0;
  assign bus_wdata = in_bus ? wdat : '0;
  assign data_cap  = dcap_q;
  assign ctrl_cap  = {16'd0, cnt_sat, 2'b00, ovr_q, algn_q,
                      tmo_q, err_q, done_q, in_bus};

endmodule
